// File: rtl/ex_muldiv_ctl.sv
// Iterative HI/LO multiply/divide unit for the EX stage: 32-cycle shift-add multiply, restoring divide.
// Define MULDIV_SIGNED_EN to honour EX_insigned; otherwise every op is unsigned.
module ex_muldiv_ctl (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_instartmul,
    input  logic        EX_instartdiv,
    input  logic        EX_insigned,
    input  logic [31:0] EX_inopA,
    input  logic [31:0] EX_inopB,
    input  logic        EX_inrdhilo,
    input  logic        EX_inflush,
    output logic        EX_outstall,
    output logic        EX_outbusy,
    output logic        EX_outdone,
    output logic        EX_outdivzero,
    output logic [31:0] EX_outhi,
    output logic [31:0] EX_outlo
);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [63:0] acc;     // mul: {hi,lo} accumulator; div: quotient/dividend in [31:0]
    logic [31:0] rem;
    logic [31:0] opd;     // multiplicand or divisor magnitude
    logic        is_div, neg_lo, neg_hi;
    logic [31:0] hi, lo;
    logic        busy, done, divzero;

    logic sgn;
`ifdef MULDIV_SIGNED_EN
    assign sgn = EX_insigned;
`else
    logic unused_signed;
    assign sgn           = 1'b0;
    assign unused_signed = EX_insigned;
`endif

    logic        sa, sb;
    logic [31:0] a_mag, b_mag;
    assign sa    = sgn & EX_inopA[31];
    assign sb    = sgn & EX_inopB[31];
    assign a_mag = sa ? -EX_inopA : EX_inopA;
    assign b_mag = sb ? -EX_inopB : EX_inopB;

    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opd : 32'd0)};

    logic [32:0] rem_sh;
    logic        ge;
    logic [31:0] rem_nxt;
    assign rem_sh  = {rem, acc[31]};
    assign ge      = rem_sh >= {1'b0, opd};
    assign rem_nxt = ge ? 32'(rem_sh - {1'b0, opd}) : rem_sh[31:0];

    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_lo ? -acc : acc;
    assign quo_fix  = neg_lo ? -acc[31:0] : acc[31:0];
    assign rem_fix  = neg_hi ? -rem : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            rem     <= '0;
            opd     <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (!EX_inflush && (EX_instartmul || EX_instartdiv)) begin
                        cnt <= '0;
                        if (EX_instartmul) begin
                            state   <= MUL;
                            busy    <= 1'b1;
                            divzero <= 1'b0;
                            is_div  <= 1'b0;
                            acc     <= {32'd0, b_mag};
                            opd     <= a_mag;
                            neg_lo  <= sa ^ sb;
                            neg_hi  <= sa ^ sb;
                        end else if (EX_inopB == 32'd0) begin
                            // divide-by-zero short-circuits straight to the done pulse
                            state   <= DONE;
                            done    <= 1'b1;
                            divzero <= 1'b1;
                            hi      <= EX_inopA;
                            lo      <= 32'hFFFF_FFFF;
                        end else begin
                            state   <= DIV;
                            busy    <= 1'b1;
                            divzero <= 1'b0;
                            is_div  <= 1'b1;
                            acc     <= {32'd0, a_mag};
                            rem     <= '0;
                            opd     <= b_mag;
                            neg_lo  <= sa ^ sb;
                            neg_hi  <= sa;
                        end
                    end
                end
                MUL, DIV: begin
                    if (EX_inflush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (state == MUL) begin
                            acc <= {mul_sum, acc[31:1]};
                        end else begin
                            rem       <= rem_nxt;
                            acc[31:0] <= {acc[30:0], ge};
                        end
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) state <= FIX;
                    end
                end
                FIX: begin
                    state <= EX_inflush ? IDLE : DONE;
                    busy  <= 1'b0;
                    if (!EX_inflush) begin
                        done <= 1'b1;
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign EX_outbusy    = busy;
    assign EX_outdone    = done;
    assign EX_outdivzero = divzero;
    assign EX_outhi      = hi;
    assign EX_outlo      = lo;
    assign EX_outstall   = busy & (EX_inrdhilo | EX_instartmul | EX_instartdiv);
endmodule

// File: tb/tb_ex_muldiv_ctl.sv
// Scoreboard bench for ex_muldiv_ctl: driver pushes model results, monitor pops on EX_outdone.
module tb_ex_muldiv_ctl;
`ifdef MULDIV_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startmul = 1'b0, startdiv = 1'b0, sgnd = 1'b0, rdhilo = 1'b0, flush = 1'b0;
    logic [31:0] opa = '0, opb = '0;
    logic        stall, busy, done, divzero;
    logic [31:0] hi, lo;

    ex_muldiv_ctl dut (
        .clk(clk), .reset(reset),
        .EX_instartmul(startmul), .EX_instartdiv(startdiv), .EX_insigned(sgnd),
        .EX_inopA(opa), .EX_inopB(opb), .EX_inrdhilo(rdhilo), .EX_inflush(flush),
        .EX_outstall(stall), .EX_outbusy(busy), .EX_outdone(done),
        .EX_outdivzero(divzero), .EX_outhi(hi), .EX_outlo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dz;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_tests = 0, n_fail = 0;
    logic [31:0] last_hi = '0, last_lo = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural operands.
    function automatic exp_t model(input bit m, input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up;
        logic [63:0] p;
        bit sg = s && SGN_EN;
        e.dz = 1'b0; e.lat = 33; e.acc_cyc = 0;
        sa = $signed(a); sb = $signed(b); ua = a; ub = b;
        if (m) begin
            if (sg) begin sp = sa * sb; p = sp; end
            else begin up = ua * ub; p = up; end
            e.hi = p[63:32]; e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.hi = a; e.lo = 32'hFFFF_FFFF; e.dz = 1'b1; e.lat = 0;
        end else if (sg) begin
            sq = sa / sb; sr = sa % sb;
            e.lo = sq[31:0]; e.hi = sr[31:0];
        end else begin
            e.lo = 32'(ua / ub); e.hi = 32'(ua % ub);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("hi", {32'd0, hi}, {32'd0, e.hi});
                chk("lo", {32'd0, lo}, {32'd0, e.lo});
                chk("divzero", {63'd0, divzero}, {63'd0, e.dz});
                chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                last_hi = e.hi; last_lo = e.lo;
            end
        end
    end

    task automatic start(input bit m, input bit d, input bit s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        startmul = m; startdiv = d; sgnd = s; opa = a; opb = b;
        @(posedge clk); #1;
        startmul = 1'b0; startdiv = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            chk("done_timeout", 64'd1, 64'd0);
            q.delete();
        end
    endtask

    task automatic issue(input bit m, input bit d, input bit s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(m, s, a, b);
        start(m, d, s, a, b);
        e.acc_cyc = cyc;
        q.push_back(e);
        drain();
    endtask

    initial begin
        exp_t e;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; rdhilo = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_dz", {63'd0, divzero}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        rdhilo = 1'b0;

        issue(1, 0, 0, 32'd7, 32'd6);
        issue(1, 0, 1, 32'hFFFF_FFFD, 32'd5);
        issue(0, 1, 0, 32'd100, 32'd7);
        issue(0, 1, 1, 32'hFFFF_FFF9, 32'd2);
        issue(0, 1, 0, 32'd5, 32'd0);
        issue(1, 1, 0, 32'd1000, 32'd3);
        issue(1, 0, 1, 32'h8000_0000, 32'h8000_0000);
        issue(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        for (int i = 0; i < 30; i++) begin
            int op;
            logic [31:0] a, b;
            op = $urandom_range(2);
            a  = $urandom;
            b  = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(1) == 1) b = b >> $urandom_range(31);
            issue(op != 1, op != 0, 1'($urandom_range(1)), a, b);
        end

        // mfhi from cycle 10: stall must hold through FIX (cycle 33) and drop in DONE
        e = model(1, 0, 32'd12345, 32'd678);
        start(1, 0, 0, 32'd12345, 32'd678);
        e.acc_cyc = cyc;
        q.push_back(e);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 10) rdhilo = 1'b1;
            #1;
            if (k >= 10) chk($sformatf("stall_c%0d", k), {63'd0, stall}, {63'd0, k <= 33});
            if (k == 20) chk("hilo_hidden", {hi, lo}, {last_hi, last_lo});
        end
        rdhilo = 1'b0;
        drain();

        // flush at cycle 20: back to IDLE, HI/LO kept, no done pulse
        start(1, 0, 0, 32'd99, 32'd77);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("flush_hilo", {hi, lo}, {last_hi, last_lo});

        // flush in IDLE suppresses a same-cycle start
        @(negedge clk);
        flush = 1'b1; startdiv = 1'b1; opa = 32'd9; opb = 32'd0;
        @(posedge clk); #1;
        flush = 1'b0; startdiv = 1'b0;
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_flush_hilo", {hi, lo}, {last_hi, last_lo});

        // reset during a divide, with divzero and HI/LO non-zero beforehand
        issue(0, 1, 0, 32'd5, 32'd0);
        start(0, 1, 0, 32'd1234567, 32'd89);
        repeat (14) @(negedge clk);
        reset = 1'b1; rdhilo = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_dz", {63'd0, divzero}, 64'd0);
        chk("midrst_hilo", {hi, lo}, 64'd0);
        chk("midrst_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        reset = 1'b0; rdhilo = 1'b0;
        last_hi = '0; last_lo = '0;
        repeat (40) @(posedge clk);
        #1;
        chk("post_rst_idle", {63'd0, busy}, 64'd0);

        issue(1, 0, 0, 32'd7, 32'd6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
